// File: rtl/cpu_bus_ram_target.sv
// Request/ready bus target fronting a 2^SIZE x 32 word RAM with WAIT_STATES programmable wait cycles.
// o_ready rises WAIT_STATES+2 edges after the request is sampled; optional counters under CPU_BUS_RAM_TARGET_STATS_EN.
module cpu_bus_ram_target #(
    parameter int unsigned SIZE        = 12,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE        = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_error
`ifdef CPU_BUS_RAM_TARGET_STATS_EN
    ,
    output logic [31:0] o_reads,
    output logic [31:0] o_writes,
    output logic [31:0] o_errors
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESPOND,
        S_RELEASE
    } state_t;

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              rw_q;
    logic              hit_q;
    logic [SIZE-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       ram_rd_q;
    logic [31:0]       rdata_q;
    logic              ready_q;
    logic              error_q;

    logic [31:0]       off_d;
    logic              hit_d;
    logic [SIZE-1:0]   idx_d;

    logic [31:0]       mem [2**SIZE];

    // Addresses below BASE wrap to large offsets and fall outside the window.
    always_comb begin
        off_d = i_address - BASE;
        hit_d = ({1'b0, off_d} < (33'd4 << SIZE));
        idx_d = off_d[SIZE+1:2];
    end

    always_ff @(posedge i_clock) begin
        if (state_q == S_ACCESS) begin
            if (hit_q && rw_q) begin
                mem[idx_q] <= wdata_q;
            end
            ram_rd_q <= hit_q ? mem[idx_q] : 32'h0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_request) begin
                        rw_q    <= i_rw;
                        hit_q   <= hit_d;
                        idx_q   <= idx_d;
                        wdata_q <= i_wdata;
                        cnt_q   <= WS4;
                        state_q <= (WS4 != 4'd0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: state_q <= S_RESPOND;
                S_RESPOND: begin
                    ready_q <= 1'b1;
                    error_q <= !hit_q;
                    if (!rw_q) begin
                        rdata_q <= ram_rd_q;
                    end
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!i_request) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rdata = rdata_q;
    assign o_ready = ready_q;
    assign o_error = error_q;

`ifdef CPU_BUS_RAM_TARGET_STATS_EN
    logic [31:0] reads_q;
    logic [31:0] writes_q;
    logic [31:0] errors_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            reads_q  <= 32'h0;
            writes_q <= 32'h0;
            errors_q <= 32'h0;
        end else if (state_q == S_RESPOND) begin
            if (!hit_q) begin
                errors_q <= errors_q + 32'd1;
            end else if (rw_q) begin
                writes_q <= writes_q + 32'd1;
            end else begin
                reads_q <= reads_q + 32'd1;
            end
        end
    end

    assign o_reads  = reads_q;
    assign o_writes = writes_q;
    assign o_errors = errors_q;
`endif

endmodule

// File: tb/tb_cpu_bus_ram_target.sv
// Bench for cpu_bus_ram_target: a WAIT_STATES=2 target at 0x1000_0000 and a WAIT_STATES=0 target at 0.
// Vector table plus scoreboard; hand sequences cover reset mid-transaction and early request drop.
module tb_cpu_bus_ram_target;

    localparam logic [31:0] BASE_A = 32'h1000_0000;
    localparam int WS_A = 2;
    localparam int WS_B = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, rw;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, error_a, error_b;
`ifdef CPU_BUS_RAM_TARGET_STATS_EN
    logic [31:0] reads_a, writes_a, errors_a;
    logic [31:0] reads_b, writes_b, errors_b;
`endif

    always #5 clk = ~clk;

    cpu_bus_ram_target #(.SIZE(12), .WAIT_STATES(WS_A), .BASE(BASE_A)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_request(req_a), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata),
        .o_rdata(rdata_a), .o_ready(ready_a), .o_error(error_a)
`ifdef CPU_BUS_RAM_TARGET_STATS_EN
        , .o_reads(reads_a), .o_writes(writes_a), .o_errors(errors_a)
`endif
    );

    cpu_bus_ram_target #(.SIZE(12), .WAIT_STATES(WS_B), .BASE(32'h0)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_request(req_b), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata),
        .o_rdata(rdata_b), .o_ready(ready_b), .o_error(error_b)
`ifdef CPU_BUS_RAM_TARGET_STATS_EN
        , .o_reads(reads_b), .o_writes(writes_b), .o_errors(errors_b)
`endif
    );

    typedef struct {
        bit          sel;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          sel;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        int          hold;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vecs[20];
    int          tests = 0;
    int          fails = 0;
    int          pulses_a = 0;
    int          pulses_b = 0;
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every o_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready_a) pulses_a++;
        if (ready_b) pulses_b++;
        if (ready_a || ready_b) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_ready: got ready_a=%b ready_b=%b expected no pulse", ready_a, ready_b);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_target", {31'h0, ready_b}, {31'h0, mon_e.sel});
                check("resp_rdata", mon_e.sel ? rdata_b : rdata_a, mon_e.rdata);
                check("resp_error", {31'h0, mon_e.sel ? error_b : error_a}, {31'h0, mon_e.err});
            end
        end
    end

    task automatic expect_resp(input bit sel, input logic w, input logic [31:0] rd, input logic err);
        exp_t e;
        e.sel = sel;
        e.err = err;
        if (w) begin
            e.rdata = sel ? last_b : last_a;
        end else begin
            e.rdata = rd;
            if (sel) last_b = rd; else last_a = rd;
        end
        sb_q.push_back(e);
    endtask

    task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic err, input int hold, input string name);
        int edges;
        int p0;
        bit seen;
        edges = 0;
        seen  = 1'b0;
        p0    = sel ? pulses_b : pulses_a;
        expect_resp(sel, w, rd, err);
        rw = w; addr = a; wdata = d;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                rw = ~w; addr = $urandom; wdata = $urandom;
            end
            seen = sel ? ready_b : ready_a;
        end
        check({name, " latency"}, 32'(edges), 32'((sel ? WS_B : WS_A) + 3));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        #1;
        check({name, " pulses"}, 32'((sel ? pulses_b : pulses_a) - p0), 32'd1);
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            txn(vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].err,
                vecs[i].hold, $sformatf("vec%0d", i));
        end
    endtask

    initial begin
        int p0;
        int edges;
        vecs[0]  = '{0, 1'b1, BASE_A + 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 0};
        vecs[1]  = '{0, 1'b0, BASE_A + 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 10};
        vecs[2]  = '{0, 1'b1, BASE_A,            32'hCAFEF00D, 32'h0,        1'b0, 0};
        vecs[3]  = '{0, 1'b1, BASE_A + 32'h3FFC, 32'h11111111, 32'h0,        1'b0, 0};
        vecs[4]  = '{0, 1'b0, BASE_A + 32'h3FFC, 32'h0,        32'h11111111, 1'b0, 0};
        vecs[5]  = '{0, 1'b1, BASE_A + 32'h4000, 32'h22222222, 32'h0,        1'b1, 0};
        vecs[6]  = '{0, 1'b0, BASE_A + 32'h4000, 32'h0,        32'h0,        1'b1, 0};
        vecs[7]  = '{0, 1'b0, BASE_A,            32'h0,        32'hCAFEF00D, 1'b0, 0};
        vecs[8]  = '{0, 1'b0, 32'h0FFF_FFFC,     32'h0,        32'h0,        1'b1, 0};
        vecs[9]  = '{0, 1'b1, BASE_A + 32'h13,   32'h12345678, 32'h0,        1'b0, 0};
        vecs[10] = '{0, 1'b0, BASE_A + 32'h10,   32'h0,        32'h12345678, 1'b0, 0};
        vecs[11] = '{0, 1'b1, BASE_A + 32'h20,   32'hA5A5A5A5, 32'h0,        1'b0, 0};
        vecs[12] = '{1, 1'b1, 32'h0,             32'h13579BDF, 32'h0,        1'b0, 0};
        vecs[13] = '{1, 1'b0, 32'h0,             32'h0,        32'h13579BDF, 1'b0, 0};
        vecs[14] = '{1, 1'b1, 32'h4000,          32'h77777777, 32'h0,        1'b1, 0};
        vecs[15] = '{1, 1'b0, 32'h4000,          32'h0,        32'h0,        1'b1, 3};
        vecs[16] = '{0, 1'b0, BASE_A + 32'h20,   32'h0,        32'hA5A5A5A5, 1'b0, 0};
        vecs[17] = '{0, 1'b0, BASE_A + 32'h3FFC, 32'h0,        32'h11111111, 1'b0, 0};
        vecs[18] = '{0, 1'b1, BASE_A + 32'h40,   32'h89ABCDEF, 32'h0,        1'b0, 0};
        vecs[19] = '{0, 1'b0, BASE_A + 32'h4004, 32'h0,        32'h0,        1'b1, 0};

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; rw = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'h0, ready_a}, 32'h0);
        check("reset error", {31'h0, error_a}, 32'h0);
        check("reset rdata", rdata_a, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_vecs(0, 15);

        // Reset while a write of 0x55 to 0x20 is still waiting: no pulse, RAM untouched.
        p0 = pulses_a;
        rw = 1'b1; addr = BASE_A + 32'h20; wdata = 32'h55; req_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_a = 1'b0;
        last_a = 32'h0; last_b = 32'h0;
        repeat (8) @(posedge clk);
        #1;
        check("midreset pulses", 32'(pulses_a - p0), 32'h0);
        check("midreset rdata", rdata_a, 32'h0);
`ifdef CPU_BUS_RAM_TARGET_STATS_EN
        check("stats reads after reset", reads_a, 32'h0);
        check("stats errors after reset", errors_a, 32'h0);
`endif
        run_vecs(16, 17);

        // Request dropped right after sampling: write still commits and o_ready still pulses.
        p0 = pulses_a;
        expect_resp(0, 1'b1, 32'h0, 1'b0);
        rw = 1'b1; addr = BASE_A + 32'h30; wdata = 32'h0BADF00D; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        edges = 1;
        while (!ready_a && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("early_drop latency", 32'(edges), 32'(WS_A + 3));
        @(posedge clk); #1;
        check("early_drop pulses", 32'(pulses_a - p0), 32'd1);
        txn(0, 1'b0, BASE_A + 32'h30, 32'h0, 32'h0BADF00D, 1'b0, 0, "early_drop readback");

        run_vecs(18, 19);
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

`ifdef CPU_BUS_RAM_TARGET_STATS_EN
        check("stats reads", reads_a, 32'd3);
        check("stats writes", writes_a, 32'd2);
        check("stats errors", errors_a, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("stats reads cleared", reads_a, 32'h0);
        check("stats writes cleared", writes_a, 32'h0);
        check("stats errors cleared", errors_a, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_bus_ram_target.md
Name: cpu_bus_ram_target

Overview:
- Bus responder (target) for the CPU-side single-word request/ready bus, which is driven by the data cache write buffer and the instruction fetch path.
- Owns a word-addressed on-chip RAM of 2^SIZE x 32 bits behind a programmable wait-state counter.
- Returns a one-cycle o_ready pulse per transaction and holds it off until the initiator drops its request.
- Flags accesses outside its window with a one-cycle error pulse.

Parameters:
- SIZE, 12, log2 of RAM depth in 32-bit words.
- WAIT_STATES, 2, extra cycles inserted before the RAM access (0..15).
- BASE, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^SIZE.

Ports:
- i_clock  input  1  clock.
- i_reset  input  1  synchronous active-high reset.
- i_request  input  1  transaction request, held by the initiator until o_ready is seen.
- i_rw  input  1  1 = write, 0 = read.
- i_address  input  32  byte address; bits [1:0] ignored.
- i_wdata  input  32  write data.
- o_rdata  output  32  read data, valid while o_ready = 1.
- o_ready  output  1  one-cycle completion pulse.
- o_error  output  1  one-cycle pulse coincident with o_ready for an out-of-window access.

Behaviour:
- Reset (synchronous, active-high) values: o_ready = 0, o_error = 0, o_rdata = 0, state IDLE, wait counter 0. RAM contents are not affected by reset.
- Window: hit when (i_address - BASE) < 4*2^SIZE, evaluated as an unsigned 32-bit compare. Word index = (i_address - BASE)[SIZE+1:2].
- States:
  - IDLE: when i_request = 1, latch rw, address, wdata and the hit flag; load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES > 0, else to ACCESS.
  - WAIT: decrement the counter; go to ACCESS on the cycle the counter reaches 1.
  - ACCESS: on a hit, write the RAM (rw = 1) or read the RAM (rw = 0) with 1-cycle latency. On a miss, the write is discarded and read data is forced to 0.
  - RESPOND: o_ready = 1 for exactly this cycle. o_rdata = RAM word for a hit read, 0 for a miss read, and holds its previous value for a write. o_error = !hit.
  - RELEASE: wait for i_request = 0, then go to IDLE. o_ready is never reasserted while the same request is still held. This matches the initiators' "request && !ready" pattern.
- Latency: if i_request is first sampled high at edge E, o_ready is high in the cycle after edge E + WAIT_STATES + 2. With WAIT_STATES = 2, o_ready rises 4 edges after the sampling edge.
- Inputs are sampled only in IDLE. Changes to address, data or rw during WAIT, ACCESS or RESPOND are ignored.
- Early request drop (protocol violation): the transaction still completes. The write is committed, o_ready still pulses, and RELEASE exits on the next cycle.
- Back-to-back transactions: a new request is accepted at the earliest 1 cycle after i_request is observed low in RELEASE. Minimum spacing is therefore WAIT_STATES + 4 cycles.
- Reset mid-transaction: the return to IDLE is immediate and no o_ready pulse is produced. A write that has not yet reached ACCESS is dropped; a write already performed in ACCESS stays committed.
- Address wrap: BASE + 4*2^SIZE - 4 hits the last word; BASE + 4*2^SIZE misses. Any address below BASE wraps in the subtraction to a large value and therefore misses.

Optional Feature:
- Macro: CPU_BUS_RAM_TARGET_STATS_EN.
- When defined:
  - Adds outputs o_reads[31:0], o_writes[31:0] and o_errors[31:0].
  - Each counter increments in the RESPOND cycle of the matching transaction; a miss increments o_errors only.
  - Counters are cleared by reset and wrap modulo 2^32.
- When undefined: these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Write/read, WAIT_STATES = 2: write 0xDEADBEEF to 0x10, then read 0x10. Each o_ready rises exactly 4 edges after request sampling; the read returns 0xDEADBEEF with o_error = 0.
- Hold request for 10 cycles after o_ready: exactly one o_ready pulse. A new request raised 1 cycle after the drop is accepted.
- Window edges, SIZE = 12, BASE = 0x1000_0000: write 0x11111111 to 0x1000_3FFC, read it back with o_error = 0. Write 0x22222222 to 0x1000_4000: o_error = 1. A read of 0x1000_4000 returns 0 with o_error = 1. Word 0 is unchanged.
- Reset asserted during WAIT of a write of 0x55 to 0x20: no o_ready pulse; a subsequent read of 0x20 returns the prior contents.
- WAIT_STATES = 0: read latency is 2 edges; a write to 0x0 followed by a read of 0x0 returns the written value.
- With CPU_BUS_RAM_TARGET_STATS_EN: 3 reads, 2 writes and 1 out-of-window access give o_reads = 3, o_writes = 2, o_errors = 1; after reset all three are 0.
